// File: rtl/mem_pkg.sv
// Shared definitions for the memory access sequencer: state encoding and bus defaults.
package mem_pkg;

    localparam int unsigned MEM_DATA_W = 16;
    localparam int unsigned MEM_ADDR_W = 16;
    localparam int unsigned MEM_WORDS  = 256;
    localparam int unsigned CNT_W      = 4;

    localparam logic [15:0] ALIGN_MASK = 16'h0001;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERR    = 2'd3
    } state_e;

endpackage

// File: rtl/mac_wait_timer.sv
// Loadable down-counter that paces the memory strobe; zero flags the capture/commit cycle.
module mac_wait_timer
    import mem_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         zero_q, zero_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
        zero_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences one fetch/load/store at a time onto the unified memory, holding the
// strobe for WAIT_CYCLES extra cycles and capturing read data into IR or MDR.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W      = MEM_DATA_W,
    parameter int unsigned ADDR_W      = MEM_ADDR_W,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_is_fetch,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              done,
    output logic              misalign_err,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic              fetch_q, fetch_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              req_ready_q, req_ready_d;
    logic              done_q, done_d;
    logic              misalign_err_q, misalign_err_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;

    logic tmr_load, tmr_dec, tmr_zero;
    logic addr_odd;

    assign addr_odd = ((req_addr & ADDR_W'(ALIGN_MASK)) != '0);

    mac_wait_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        fetch_d     = fetch_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    fetch_d = req_is_fetch;
                    if (addr_odd) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                        tmr_load    = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                end else begin
                    // Last strobe cycle: reads capture here, stores commit in memory.
                    if (!write_q) begin
                        if (fetch_q) ir_d  = mem_rdata;
                        else         mdr_d = mem_rdata;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        req_ready_d    = (state_d == ST_IDLE);
        done_d         = (state_d == ST_RESP);
        misalign_err_d = (state_d == ST_ERR);
        mem_read_d     = (state_d == ST_ACCESS) && !write_d;
        mem_write_d    = (state_d == ST_ACCESS) &&  write_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            write_q        <= 1'b0;
            fetch_q        <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            ir_q           <= '0;
            mdr_q          <= '0;
            req_ready_q    <= 1'b1;
            done_q         <= 1'b0;
            misalign_err_q <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            fetch_q        <= fetch_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            ir_q           <= ir_d;
            mdr_q          <= mdr_d;
            req_ready_q    <= req_ready_d;
            done_q         <= done_d;
            misalign_err_q <= misalign_err_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign done         = done_q;
    assign misalign_err = misalign_err_q;
    assign ir           = ir_q;
    assign mdr          = mdr_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: two controllers (WAIT_CYCLES=1 and 0), each with its own memory model.
module tb_mem_access_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cyc;

    // DUT A (WAIT_CYCLES = 1)
    logic        a_valid = 1'b0, a_write = 1'b0, a_fetch = 1'b0;
    logic [15:0] a_addr = '0, a_wdata = '0;
    logic        a_ready, a_done, a_err, a_mrd, a_mwr;
    logic [15:0] a_ir, a_mdr, a_maddr, a_mwdata, a_mrdata;
    logic [15:0] mem_a [256];

    // DUT B (WAIT_CYCLES = 0)
    logic        b_valid = 1'b0, b_write = 1'b0, b_fetch = 1'b0;
    logic [15:0] b_addr = '0, b_wdata = '0;
    logic        b_ready, b_done, b_err, b_mrd, b_mwr;
    logic [15:0] b_ir, b_mdr, b_maddr, b_mwdata, b_mrdata;
    logic [15:0] mem_b [256];

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
        .req_is_fetch(a_fetch), .req_addr(a_addr), .req_wdata(a_wdata),
        .done(a_done), .misalign_err(a_err), .ir(a_ir), .mdr(a_mdr),
        .mem_read(a_mrd), .mem_write(a_mwr), .mem_addr(a_maddr),
        .mem_wdata(a_mwdata), .mem_rdata(a_mrdata)
    );

    mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
        .req_is_fetch(b_fetch), .req_addr(b_addr), .req_wdata(b_wdata),
        .done(b_done), .misalign_err(b_err), .ir(b_ir), .mdr(b_mdr),
        .mem_read(b_mrd), .mem_write(b_mwr), .mem_addr(b_maddr),
        .mem_wdata(b_mwdata), .mem_rdata(b_mrdata)
    );

    // Memory models: combinational read gated by mem_read, write on posedge.
    assign a_mrdata = a_mrd ? mem_a[a_maddr[8:1]] : 16'h0000;
    assign b_mrdata = b_mrd ? mem_b[b_maddr[8:1]] : 16'h0000;

    always @(posedge clk) begin
        if (a_mwr) mem_a[a_maddr[8:1]] <= a_mwdata;
        if (b_mwr) mem_b[b_maddr[8:1]] <= b_mwdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] b2b_addr [3];
        logic [15:0] b2b_exp  [3];
        b2b_addr[0] = 16'h0004; b2b_exp[0] = 16'h1234;
        b2b_addr[1] = 16'h000A; b2b_exp[1] = 16'hA5A5;
        b2b_addr[2] = 16'h0004; b2b_exp[2] = 16'h1234;

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 16'h0000;
            mem_b[i] = 16'h0000;
        end
        mem_a[2] = 16'h1234; mem_a[5] = 16'hBEEF;
        mem_b[2] = 16'h1234; mem_b[5] = 16'hBEEF;

        // Reset state
        rst = 1'b1;
        step(); step();
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_done",  32'(a_done),  32'd0);
        chk("rst_err",   32'(a_err),   32'd0);
        chk("rst_strb",  32'({a_mrd, a_mwr}), 32'd0);
        chk("rst_ir",    32'(a_ir),    32'd0);
        chk("rst_mdr",   32'(a_mdr),   32'd0);
        chk("rst_maddr", 32'(a_maddr), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_ready", 32'(a_ready), 32'd1);

        // 1. Fetch from 0x0004, WAIT_CYCLES=1
        a_valid = 1'b1; a_write = 1'b0; a_fetch = 1'b1; a_addr = 16'h0004;
        step();
        a_valid = 1'b0;
        chk("f_c1_rd",    32'(a_mrd),   32'd1);
        chk("f_c1_addr",  32'(a_maddr), 32'h0004);
        chk("f_c1_ready", 32'(a_ready), 32'd0);
        chk("f_c1_done",  32'(a_done),  32'd0);
        step();
        chk("f_c2_rd",    32'(a_mrd),   32'd1);
        chk("f_c2_done",  32'(a_done),  32'd0);
        step();
        chk("f_c3_done",  32'(a_done),  32'd1);
        chk("f_c3_rd",    32'(a_mrd),   32'd0);
        chk("f_c3_ir",    32'(a_ir),    32'h1234);
        chk("f_c3_mdr",   32'(a_mdr),   32'h0000);
        chk("f_c3_ready", 32'(a_ready), 32'd0);
        step();
        chk("f_c4_done",  32'(a_done),  32'd0);
        chk("f_c4_ready", 32'(a_ready), 32'd1);

        // 2. Store 0xA5A5 to 0x000A then load it back into MDR
        a_valid = 1'b1; a_write = 1'b1; a_fetch = 1'b0; a_addr = 16'h000A; a_wdata = 16'hA5A5;
        step();
        a_valid = 1'b0;
        chk("s_c1_wr",    32'(a_mwr),    32'd1);
        chk("s_c1_rd",    32'(a_mrd),    32'd0);
        chk("s_c1_wdata", 32'(a_mwdata), 32'hA5A5);
        step();
        chk("s_c2_wr",    32'(a_mwr),    32'd1);
        step();
        chk("s_c3_wr",    32'(a_mwr),    32'd0);
        chk("s_c3_done",  32'(a_done),   32'd1);
        step();
        a_valid = 1'b1; a_write = 1'b0; a_fetch = 1'b0; a_addr = 16'h000A; a_wdata = 16'h0000;
        step();
        a_valid = 1'b0;
        chk("l_c1_rd",    32'(a_mrd),   32'd1);
        step();
        step();
        chk("l_c3_done",  32'(a_done),  32'd1);
        chk("l_c3_mdr",   32'(a_mdr),   32'hA5A5);
        chk("l_c3_ir",    32'(a_ir),    32'h1234);
        step();

        // 3. Misaligned request at 0x0003
        a_valid = 1'b1; a_write = 1'b0; a_fetch = 1'b1; a_addr = 16'h0003;
        step();
        a_valid = 1'b0;
        chk("e_c1_err",   32'(a_err),   32'd1);
        chk("e_c1_strb",  32'({a_mrd, a_mwr}), 32'd0);
        chk("e_c1_done",  32'(a_done),  32'd0);
        chk("e_c1_maddr", 32'(a_maddr), 32'h000A);
        step();
        chk("e_c2_err",   32'(a_err),   32'd0);
        chk("e_c2_strb",  32'({a_mrd, a_mwr}), 32'd0);
        chk("e_c2_done",  32'(a_done),  32'd0);
        chk("e_c2_ready", 32'(a_ready), 32'd1);
        chk("e_c2_ir",    32'(a_ir),    32'h1234);
        chk("e_c2_mdr",   32'(a_mdr),   32'hA5A5);

        // 4. Reset during the ACCESS of a load
        a_valid = 1'b1; a_write = 1'b0; a_fetch = 1'b0; a_addr = 16'h000A;
        step();
        a_valid = 1'b0;
        chk("r_c1_rd",    32'(a_mrd),   32'd1);
        rst = 1'b1;
        step();
        chk("r_c2_strb",  32'({a_mrd, a_mwr}), 32'd0);
        chk("r_c2_ir",    32'(a_ir),    32'd0);
        chk("r_c2_mdr",   32'(a_mdr),   32'd0);
        chk("r_c2_done",  32'(a_done),  32'd0);
        chk("r_c2_ready", 32'(a_ready), 32'd1);
        rst = 1'b0;
        step();
        chk("r_c3_done",  32'(a_done),  32'd0);
        chk("r_c3_rd",    32'(a_mrd),   32'd0);

        // 5. Three back-to-back fetches with req_valid held high
        a_valid = 1'b1; a_write = 1'b0; a_fetch = 1'b1; a_addr = b2b_addr[0];
        done_cyc = -1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i < 2) a_addr = b2b_addr[i + 1];
            chk($sformatf("b2b%0d_c1_ready", i), 32'(a_ready), 32'd0);
            step();
            chk($sformatf("b2b%0d_c2_ready", i), 32'(a_ready), 32'd0);
            step();
            chk($sformatf("b2b%0d_done", i),  32'(a_done),  32'd1);
            chk($sformatf("b2b%0d_ir", i),    32'(a_ir),    32'(b2b_exp[i]));
            chk($sformatf("b2b%0d_c3_ready", i), 32'(a_ready), 32'd0);
            if (done_cyc >= 0) chk($sformatf("b2b%0d_spacing", i), 32'(cyc - done_cyc), 32'd4);
            done_cyc = cyc;
            if (i == 2) a_valid = 1'b0;
            step();
            chk($sformatf("b2b%0d_idle_ready", i), 32'(a_ready), 32'd1);
            chk($sformatf("b2b%0d_idle_done", i),  32'(a_done),  32'd0);
        end

        // 6. WAIT_CYCLES=0 instance: fetch from 0x0004
        b_valid = 1'b1; b_write = 1'b0; b_fetch = 1'b1; b_addr = 16'h0004;
        step();
        b_valid = 1'b0;
        chk("w0_c1_rd",   32'(b_mrd),  32'd1);
        chk("w0_c1_done", 32'(b_done), 32'd0);
        step();
        chk("w0_c2_done", 32'(b_done), 32'd1);
        chk("w0_c2_rd",   32'(b_mrd),  32'd0);
        chk("w0_c2_ir",   32'(b_ir),   32'h1234);
        step();
        chk("w0_c3_ready", 32'(b_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
